// File: rtl/gp_lpddr5_ca_decoder_if.sv
// rtl/gp_lpddr5_ca_decoder_if.sv - decoded-command stream between CA decoder and its consumer
// cmd_tstamp exists only when GP_LPDDR5_CA_TSTAMP_EN is defined.
interface gp_lpddr5_ca_decoder_if #(
    parameter int TS_W = 32
);
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_code;
    logic [1:0]  cmd_rank;
    logic [13:0] cmd_arg;
`ifdef GP_LPDDR5_CA_TSTAMP_EN
    logic [TS_W-1:0] cmd_tstamp;

    modport master (output cmd_valid, cmd_code, cmd_rank, cmd_arg, cmd_tstamp, input cmd_ready);
    modport slave  (input cmd_valid, cmd_code, cmd_rank, cmd_arg, cmd_tstamp, output cmd_ready);
`else
    modport master (output cmd_valid, cmd_code, cmd_rank, cmd_arg, input cmd_ready);
    modport slave  (input cmd_valid, cmd_code, cmd_rank, cmd_arg, output cmd_ready);
`endif
endinterface

// File: rtl/gp_lpddr5_ca_decoder.sv
// rtl/gp_lpddr5_ca_decoder.sv - LPDDR5 CA bus command decoder with output FIFO and error flags
// Optional per-entry timestamps enabled by GP_LPDDR5_CA_TSTAMP_EN.
module gp_lpddr5_ca_decoder #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 32
) (
    input  logic                    ck_t,
    input  logic                    ddr_reset_n,
    input  logic                    cs0,
    input  logic                    cs1,
    input  logic [6:0]              ca,
    gp_lpddr5_ca_decoder_if.master  cmd,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic [2:0]              err_sticky,
    input  logic                    err_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [4:0] C_NONE = 5'd0;
    localparam logic [4:0] C_RD16 = 5'd1;
    localparam logic [4:0] C_RD32 = 5'd2;
    localparam logic [4:0] C_MWR  = 5'd3;
    localparam logic [4:0] C_WR16 = 5'd4;
    localparam logic [4:0] C_WR32 = 5'd5;
    localparam logic [4:0] C_CAS  = 5'd6;
    localparam logic [4:0] C_PRE  = 5'd7;
    localparam logic [4:0] C_REF  = 5'd8;
    localparam logic [4:0] C_MRR  = 5'd9;
    localparam logic [4:0] C_SRE  = 5'd10;
    localparam logic [4:0] C_MPC  = 5'd11;
    localparam logic [4:0] C_WFF  = 5'd12;
    localparam logic [4:0] C_RFF  = 5'd13;
    localparam logic [4:0] C_PDE  = 5'd14;
    localparam logic [4:0] C_ACT  = 5'd15;
    localparam logic [4:0] C_MRW  = 5'd16;
    localparam logic [4:0] C_UNK  = 5'd31;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACT2 = 2'd1,
        WAIT_MRW2 = 2'd2
    } state_t;

    state_t state, state_next;

    // Opcodes and arg halves are pin-ordered: ca0 sits in the MSB.
    logic [6:0] pin;
    logic       cs_any;
    logic [1:0] rank_now;

    assign pin      = {ca[0], ca[1], ca[2], ca[3], ca[4], ca[5], ca[6]};
    assign cs_any   = cs0 | cs1;
    assign rank_now = {cs1, cs0};

    logic [4:0] dec_code;
    state_t     dec_next;

    always_comb begin
        dec_code = C_NONE;
        dec_next = IDLE;
        if (cs_any) begin
            casez (pin)
                7'b111????: dec_next = WAIT_ACT2;
                7'b100????: dec_code = C_RD16;
                7'b101????: dec_code = C_RD32;
                7'b010????: dec_code = C_MWR;
                7'b011????: dec_code = C_WR16;
                7'b0010???: dec_code = C_WR32;
                7'b0011???: dec_code = C_CAS;
                7'b0001111: dec_code = C_PRE;
                7'b0001110: dec_code = C_REF;
                7'b0001101: dec_next = WAIT_MRW2;
                7'b0001100: dec_code = C_MRR;
                7'b0001011: dec_code = C_SRE;
                7'b000011?: dec_code = C_MPC;
                7'b0000011: dec_code = C_WFF;
                7'b0000010: dec_code = C_RFF;
                7'b0000001: dec_code = C_PDE;
                7'b0000000: dec_code = C_NONE;
                default:    dec_code = C_UNK;
            endcase
        end
    end

    logic [6:0] first_pin;
    logic [1:0] first_rank;
    logic       latch_first;
    logic       push;
    logic       use_first;
    logic [4:0] push_code;
    logic [1:0] push_rank;
    logic [13:0] push_arg;
    logic [1:0] proto_err;

    always_comb begin
        state_next  = state;
        push        = 1'b0;
        push_code   = C_NONE;
        push_rank   = rank_now;
        push_arg    = {pin, 7'd0};
        use_first   = 1'b0;
        proto_err   = 2'b00;
        latch_first = 1'b0;
        unique case (state)
            WAIT_ACT2: begin
                if (cs_any && pin[6:4] == 3'b110) begin
                    push      = 1'b1;
                    push_code = C_ACT;
                    use_first = 1'b1;
                end else begin
                    proto_err[0] = 1'b1;
                end
            end
            WAIT_MRW2: begin
                if (cs_any && pin[6:1] == 6'b000100) begin
                    push      = 1'b1;
                    push_code = C_MRW;
                    use_first = 1'b1;
                end else begin
                    proto_err[0] = 1'b1;
                end
            end
            default: ;
        endcase
        if (use_first) begin
            push_rank  = first_rank;
            push_arg   = {first_pin, pin};
            state_next = IDLE;
        end else begin
            // A broken wait falls through and this edge is decoded fresh.
            state_next   = dec_next;
            push         = (dec_code != C_NONE);
            push_code    = dec_code;
            proto_err[1] = (dec_code == C_UNK);
            latch_first  = (dec_next != IDLE);
        end
    end

    always_ff @(posedge ck_t or negedge ddr_reset_n) begin
        if (!ddr_reset_n) begin
            state      <= IDLE;
            first_pin  <= 7'd0;
            first_rank <= 2'd0;
        end else begin
            state <= state_next;
            if (latch_first) begin
                first_pin  <= pin;
                first_rank <= rank_now;
            end
        end
    end

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, pop, wr, overflow;

    logic [4:0]  mem_code [DEPTH];
    logic [1:0]  mem_rank [DEPTH];
    logic [13:0] mem_arg  [DEPTH];

    assign full     = (count == CW'(DEPTH));
    assign pop      = cmd.cmd_valid & cmd.cmd_ready;
    assign wr       = push & (~full | pop);
    assign overflow = push & full & ~pop;

    always_ff @(posedge ck_t or negedge ddr_reset_n) begin
        if (!ddr_reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err_sticky <= 3'b000;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count      <= count + CW'(wr) - CW'(pop);
            err_sticky <= (err_clr ? 3'b000 : err_sticky) | {overflow, proto_err};
        end
    end

    always_ff @(posedge ck_t) begin
        if (wr) begin
            mem_code[wr_ptr] <= push_code;
            mem_rank[wr_ptr] <= push_rank;
            mem_arg[wr_ptr]  <= push_arg;
        end
    end

    // Gating keeps the outputs at zero while empty, including out of reset.
    assign fifo_count    = count;
    assign cmd.cmd_valid = (count != '0);
    assign cmd.cmd_code  = cmd.cmd_valid ? mem_code[rd_ptr] : 5'd0;
    assign cmd.cmd_rank  = cmd.cmd_valid ? mem_rank[rd_ptr] : 2'd0;
    assign cmd.cmd_arg   = cmd.cmd_valid ? mem_arg[rd_ptr]  : 14'd0;

`ifdef GP_LPDDR5_CA_TSTAMP_EN
    logic [TS_W-1:0] ts_cnt;
    logic [TS_W-1:0] first_ts;
    logic [TS_W-1:0] mem_ts [DEPTH];

    always_ff @(posedge ck_t or negedge ddr_reset_n) begin
        if (!ddr_reset_n) begin
            ts_cnt   <= '0;
            first_ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
            if (latch_first) first_ts <= ts_cnt;
        end
    end

    always_ff @(posedge ck_t) begin
        if (wr) mem_ts[wr_ptr] <= use_first ? first_ts : ts_cnt;
    end

    assign cmd.cmd_tstamp = cmd.cmd_valid ? mem_ts[rd_ptr] : '0;
`endif
endmodule

// File: tb/tb_gp_lpddr5_ca_decoder.sv
// tb/tb_gp_lpddr5_ca_decoder.sv - directed scoreboard bench for gp_lpddr5_ca_decoder
module tb_gp_lpddr5_ca_decoder;
    localparam int DEPTH = 8;
    localparam int TS_W  = 32;

    logic       ck_t = 1'b0;
    logic       ddr_reset_n = 1'b0;
    logic       cs0 = 1'b0, cs1 = 1'b0;
    logic [6:0] ca = 7'd0;
    logic       err_clr = 1'b0;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [2:0] err_sticky;

    gp_lpddr5_ca_decoder_if #(.TS_W(TS_W)) ifc ();

    gp_lpddr5_ca_decoder #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .ck_t        (ck_t),
        .ddr_reset_n (ddr_reset_n),
        .cs0         (cs0),
        .cs1         (cs1),
        .ca          (ca),
        .cmd         (ifc.master),
        .fifo_count  (fifo_count),
        .err_sticky  (err_sticky),
        .err_clr     (err_clr)
    );

    always #5 ck_t = ~ck_t;

    typedef struct packed {
        logic [4:0]  code;
        logic [1:0]  rank;
        logic [13:0] arg;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
`ifdef GP_LPDDR5_CA_TSTAMP_EN
    logic [TS_W-1:0] ts_q[$];
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of CA in pin order (p[6] = ca0), leaving it asserted.
    task automatic drive(input logic [1:0] rank, input logic [6:0] p);
        cs0 = rank[0];
        cs1 = rank[1];
        for (int i = 0; i < 7; i++) ca[i] = p[6-i];
        @(posedge ck_t);
        #1;
    endtask

    task automatic idle(input int n);
        cs0 = 1'b0;
        cs1 = 1'b0;
        ca  = 7'd0;
        repeat (n) @(posedge ck_t);
        #1;
    endtask

    task automatic expect_cmd(input logic [4:0] code, input logic [1:0] rank, input logic [13:0] arg);
        exp_q.push_back('{code: code, rank: rank, arg: arg});
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
    endtask

    always @(negedge ck_t) begin
        if (ddr_reset_n && ifc.cmd_valid && ifc.cmd_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected observed code %0d rank %0d arg %0h expected none",
                       ifc.cmd_code, ifc.cmd_rank, ifc.cmd_arg);
            end
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                assert ({ifc.cmd_code, ifc.cmd_rank, ifc.cmd_arg} === e) else begin
                    errors++;
                    $error("FAIL sb_entry observed %0d/%0d/%0h expected %0d/%0d/%0h",
                           ifc.cmd_code, ifc.cmd_rank, ifc.cmd_arg, e.code, e.rank, e.arg);
                end
            end
`ifdef GP_LPDDR5_CA_TSTAMP_EN
            ts_q.push_back(ifc.cmd_tstamp);
`endif
        end
    end

    initial begin
        ifc.cmd_ready = 1'b1;
        repeat (3) @(posedge ck_t);
        #1;
        chk("rst_valid", 32'(ifc.cmd_valid), 32'd0);
        chk("rst_code",  32'(ifc.cmd_code),  32'd0);
        chk("rst_rank",  32'(ifc.cmd_rank),  32'd0);
        chk("rst_arg",   32'(ifc.cmd_arg),   32'd0);
        chk("rst_count", 32'(fifo_count),    32'd0);
        chk("rst_err",   32'(err_sticky),    32'd0);
        ddr_reset_n = 1'b1;
        idle(1);

        // One-cycle RD16: visible right after the capturing edge.
        expect_cmd(5'd1, 2'b01, {7'b1001000, 7'b0000000});
        drive(2'b01, 7'b1001000);
        chk("rd16_valid", 32'(ifc.cmd_valid), 32'd1);
        chk("rd16_code",  32'(ifc.cmd_code),  32'd1);
        chk("rd16_arg",   32'(ifc.cmd_arg),   32'(14'b1001000_0000000));
        idle(2);

        // Two-cycle ACT on rank 1.
        expect_cmd(5'd15, 2'b10, {7'b1110101, 7'b1100011});
        drive(2'b10, 7'b1110101);
        drive(2'b10, 7'b1100011);
        idle(2);
        chk("act_err",   32'(err_sticky),   32'd0);
        chk("act_drain", 32'(exp_q.size()), 32'd0);

        // ACT1 broken by a deselected cycle, then REF decodes normally.
        drive(2'b10, 7'b1110101);
        idle(1);
        chk("brk_err",   32'(err_sticky), 32'b001);
        chk("brk_count", 32'(fifo_count), 32'd0);
        expect_cmd(5'd8, 2'b01, {7'b0001110, 7'b0000000});
        drive(2'b01, 7'b0001110);
        idle(2);
        chk("brk_ref_drain", 32'(exp_q.size()), 32'd0);
        clear_err();
        chk("clr_err", 32'(err_sticky), 32'd0);

        // ACT1 broken by a RD32 in the same edge: RD32 still decoded.
        expect_cmd(5'd2, 2'b01, {7'b1010000, 7'b0000000});
        drive(2'b10, 7'b1110000);
        drive(2'b01, 7'b1010000);
        idle(2);
        chk("brk_rd32_err", 32'(err_sticky), 32'b001);
        clear_err();

        // MRW pair, DES with cs high (dropped), CAS on both ranks.
        expect_cmd(5'd16, 2'b01, {7'b0001101, 7'b0001000});
        drive(2'b01, 7'b0001101);
        drive(2'b01, 7'b0001000);
        drive(2'b01, 7'b0000000);
        expect_cmd(5'd6, 2'b11, {7'b0011101, 7'b0000000});
        drive(2'b11, 7'b0011101);
        idle(2);
        chk("mrw_cas_err",   32'(err_sticky),   32'd0);
        chk("mrw_cas_drain", 32'(exp_q.size()), 32'd0);

        // Unknown opcode, with err_clr in the same cycle: set wins.
        expect_cmd(5'd31, 2'b01, {7'b0001010, 7'b0000000});
        err_clr = 1'b1;
        drive(2'b01, 7'b0001010);
        err_clr = 1'b0;
        idle(2);
        chk("unk_err", 32'(err_sticky), 32'b010);
        clear_err();

        // Overflow: nine REFs with the consumer stalled.
        ifc.cmd_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < DEPTH) expect_cmd(5'd8, 2'b01, {7'b0001110, 7'b0000000});
            drive(2'b01, 7'b0001110);
        end
        idle(1);
        chk("ovf_count", 32'(fifo_count),     32'd8);
        chk("ovf_err",   32'(err_sticky),     32'b100);
        chk("ovf_hold",  32'(ifc.cmd_code),   32'd8);
        clear_err();

        // Full FIFO, push and pop on the same edge: no overflow.
        expect_cmd(5'd7, 2'b01, {7'b0001111, 7'b0000000});
        ifc.cmd_ready = 1'b1;
        drive(2'b01, 7'b0001111);
        ifc.cmd_ready = 1'b0;
        cs0 = 1'b0;
        chk("pp_count", 32'(fifo_count), 32'd8);
        chk("pp_err",   32'(err_sticky), 32'd0);

        ifc.cmd_ready = 1'b1;
        for (int i = 0; i < 40 && fifo_count != 0; i++) @(posedge ck_t);
        #1;
        chk("drain_count", 32'(fifo_count),   32'd0);
        chk("drain_sb",    32'(exp_q.size()), 32'd0);

        // Reset during a pending ACT1: lost silently, FSM back in IDLE.
        drive(2'b10, 7'b1110000);
        ddr_reset_n = 1'b0;
        idle(1);
        chk("mid_rst_err", 32'(err_sticky), 32'd0);
        ddr_reset_n = 1'b1;
        expect_cmd(5'd31, 2'b01, {7'b1100000, 7'b0000000});
        drive(2'b01, 7'b1100000);
        idle(2);
        chk("mid_rst_unk", 32'(err_sticky),   32'b010);
        chk("mid_rst_sb",  32'(exp_q.size()), 32'd0);
        clear_err();

`ifdef GP_LPDDR5_CA_TSTAMP_EN
        ts_q.delete();
        expect_cmd(5'd1, 2'b01, {7'b1000000, 7'b0000000});
        drive(2'b01, 7'b1000000);
        idle(4);
        expect_cmd(5'd1, 2'b01, {7'b1000000, 7'b0000000});
        drive(2'b01, 7'b1000000);
        idle(2);
        chk("ts_pops", 32'(ts_q.size()), 32'd2);
        if (ts_q.size() == 2) chk("ts_delta", 32'(ts_q[1] - ts_q[0]), 32'd5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gp_lpddr5_ca_decoder.md
Name: gp_lpddr5_ca_decoder

Overview:
- Front-end stage on the LPDDR5 channel CA bus, beside the channel interface.
- Samples cs0/cs1/ca0..ca6 on each rising ck_t and assembles one- and two-cycle commands (ACT, MRW) into decoded transactions.
- Buffers decoded transactions in a small FIFO with a valid/ready handshake to the monitor/scoreboard.
- Flags protocol violations: broken two-cycle commands, unknown opcodes, FIFO overflow.

Parameters:
- DEPTH, 8: FIFO entries; power of two, 2..64.
- TS_W, 32: timestamp counter width (used only with the optional feature).

Ports:
- ck_t  in  1  CA clock; all logic on its rising edge.
- ddr_reset_n  in  1  asynchronous active-low reset.
- cs0, cs1  in  1 each  chip selects; a command cycle is a rising edge with cs0|cs1 high.
- ca  in  7  CA pins, bit i = pin ca_i.
- cmd_valid  out  1  FIFO head holds a command.
- cmd_ready  in  1  consumer accepts the head when cmd_valid & cmd_ready.
- cmd_code  out  5  decoded command enum.
- cmd_rank  out  2  {cs1,cs0} of the first command cycle.
- cmd_arg  out  14  {first-cycle ca, second-cycle ca}; second half is 0 for one-cycle commands.
- fifo_count  out  $clog2(DEPTH)+1  occupancy.
- err_sticky  out  3  [0] broken two-cycle command, [1] unknown opcode, [2] overflow.
- err_clr  in  1  synchronous clear of err_sticky.
- cmd_tstamp  out  TS_W  present only with GP_LPDDR5_CA_TSTAMP_EN.

Behaviour:
- Reset: FSM=IDLE; FIFO empty; cmd_valid=0; cmd_code/cmd_rank/cmd_arg=0; fifo_count=0; err_sticky=0; cmd_tstamp=0.
- Cycles with cs0|cs1 low are ignored in IDLE.
- IDLE decode uses pins ca0..ca6, first match wins:
  - 111xxxx ACT1 -> WAIT_ACT2, latch first ca and rank.
  - 100xxxx RD16=1; 101xxxx RD32=2; 010xxxx MWR=3; 011xxxx WR16=4; 0010xxx WR32=5.
  - 0011xxx CAS=6, with subtype in arg bits ca4..ca6.
  - 0001111 PRE=7; 0001110 REF=8; 0001101 MRW1 -> WAIT_MRW2; 0001100 MRR=9; 0001011 SRE=10.
  - 000011x MPC=11; 0000011 WFF=12; 0000010 RFF=13; 0000001 PDE=14; 0000000 DES, not pushed.
  - Anything else, including 000100x MRW2 and 110xxxx ACT2 seen in IDLE -> UNKNOWN=31, pushed, err_sticky[1] set.
- WAIT_ACT2, next rising edge:
  - cs high and ca0..ca2=110 -> push ACT=15 with both ca halves; return to IDLE.
  - Otherwise set err_sticky[0], discard the ACT1, and decode this cycle as in IDLE in the same edge.
- WAIT_MRW2: same rule as WAIT_ACT2 with ca0..ca5=000100; success pushes MRW=16.
- No timeout in wait states; the next edge always resolves the wait.
- Latency: cmd_valid rises in the cycle following the completing rising edge (registered push); FIFO output is head-of-queue combinational from storage.
- FIFO:
  - Pop when cmd_valid & cmd_ready.
  - Push when full: accepted only if a pop occurs the same cycle. Otherwise the new command is dropped and err_sticky[2] is set.
  - Simultaneous push+pop when empty: push stored, pop ignored (cmd_valid was 0).
  - Pointers wrap modulo DEPTH.
- cmd_code/rank/arg are held stable while cmd_valid & !cmd_ready.
- err_clr: clears err_sticky; a same-cycle new error wins (set has priority).
- Reset mid-operation: FIFO flushed, FSM to IDLE, and any half-received two-cycle command is lost without an error.

Optional Feature:
- GP_LPDDR5_CA_TSTAMP_EN defined:
  - Free-running TS_W-bit ck_t counter, reset 0, wraps to 0.
  - Each FIFO entry stores the counter value at its first command cycle, presented on cmd_tstamp.
- Undefined: no counter, no cmd_tstamp port, no storage; all other behaviour identical.

Test Plan:
- Reset release, ca=1001000 with cs0=1, ready=1 -> cmd_valid high one cycle later; cmd_code=1, rank=01, arg=14'b1001000_0000000.
- ACT1 ca=1110101 then ca=1100011 on consecutive edges, cs1=1 -> single entry: code=15, rank=10, arg={1110101,1100011}; err_sticky=0.
- ACT1 then cs low on the next edge -> no ACT pushed; err_sticky=001; FSM back in IDLE; a following REF (0001110) is pushed with code=8.
- ready=0, issue 9 REFs with DEPTH=8 -> fifo_count=8; err_sticky[2]=1; drain returns exactly 8 REFs.
- Full FIFO, push and pop in the same cycle -> no overflow flag; fifo_count stays 8.
- ca=0001010 with cs high -> code=31, err_sticky[1]=1. With GP_LPDDR5_CA_TSTAMP_EN, two commands 5 cycles apart -> cmd_tstamp values differ by 5.
